// File: rtl/vram_text_scanout.sv
`default_nettype none
// ============================================================================
// vram_text_scanout : text VRAM read-side scanout, 8x16 font, RGB565 out
// Revision: 1.0
// ============================================================================
module vram_text_scanout #(
   parameter int unsigned COLS         = 60,
   parameter int unsigned ROWS         = 17,
   parameter logic [15:0] FG           = 16'hFFFF,
   parameter logic [15:0] BG           = 16'h0000,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic        MEMORY_CLK,
   input  logic        reset,
   input  logic [8:0]  x,
   input  logic [8:0]  y,
   input  logic        de,
   input  logic        frame_start,
   input  logic        cursor_en,
   input  logic [9:0]  cursor_addr,
   output logic [9:0]  v_adb,
   output logic        v_ceb,
   output logic        v_oce,
   input  logic [7:0]  v_dout,
   output logic [10:0] font_adr,
   input  logic [7:0]  font_dout,
   output logic [15:0] rgb,
   output logic        rgb_de
);

   localparam int unsigned CNT_W   = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [8:0]  X_LIM   = 9'(COLS * 8);
   localparam logic [8:0]  Y_LIM   = 9'(ROWS * 16);

   logic             in_range_w;
   logic [9:0]       cell_addr_w;

   logic [9:0]       v_adb_q, v_adb_d;
   logic             v_en_q, v_en_d;
   logic [4:0]       vld_q, vld_d;        // stage s valid, s = edges after sampling
   logic [4:0][2:0]  px_q, px_d;
   logic [2:0][3:0]  py_q, py_d;
   logic [2:0]       hit_q, hit_d;
   logic [10:0]      font_adr_q, font_adr_d;
   logic [1:0]       inv_q, inv_d;
   logic [15:0]      rgb_q, rgb_d;
   logic             rgb_de_q, rgb_de_d;
   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;

   assign in_range_w  = (x < X_LIM) && (y < Y_LIM);
   assign cell_addr_w = 10'(y[8:4]) * 10'(COLS) + 10'(x[8:3]);

   always_comb begin
      v_adb_d    = in_range_w ? cell_addr_w : 10'd0;
      v_en_d     = 1'b1;
      vld_d      = {vld_q[3:0], de && in_range_w};
      px_d       = {px_q[3:0], x[2:0]};
      py_d       = {py_q[1:0], y[3:0]};
      // Blink phase folded in at sampling time so a toggle affects the next pixel.
      hit_d      = {hit_q[1:0],
                    cursor_en && in_range_w && (cell_addr_w == cursor_addr) && blink_phase_q};
      font_adr_d = {v_dout[6:0], py_q[2]};
      inv_d      = {inv_q[0], v_dout[7] ^ hit_q[2]};
      rgb_de_d   = vld_q[4];
      rgb_d      = BG;
      if (vld_q[4] && (font_dout[~px_q[4]] ^ inv_q[1])) begin
         rgb_d = FG;
      end

      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_start) begin
         if (blink_cnt_q == CNT_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge MEMORY_CLK or posedge reset) begin
      if (reset) begin
         v_adb_q       <= '0;
         v_en_q        <= 1'b0;
         vld_q         <= '0;
         px_q          <= '0;
         py_q          <= '0;
         hit_q         <= '0;
         font_adr_q    <= '0;
         inv_q         <= '0;
         rgb_q         <= BG;
         rgb_de_q      <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
      end else begin
         v_adb_q       <= v_adb_d;
         v_en_q        <= v_en_d;
         vld_q         <= vld_d;
         px_q          <= px_d;
         py_q          <= py_d;
         hit_q         <= hit_d;
         font_adr_q    <= font_adr_d;
         inv_q         <= inv_d;
         rgb_q         <= rgb_d;
         rgb_de_q      <= rgb_de_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign v_adb    = v_adb_q;
   assign v_ceb    = v_en_q;
   assign v_oce    = v_en_q;
   assign font_adr = font_adr_q;
   assign rgb      = rgb_q;
   assign rgb_de   = rgb_de_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_text_scanout.sv
`default_nettype none
// ============================================================================
// tb_vram_text_scanout : randomized scanout bench with behavioural pixel model
// Revision: 1.0
// ============================================================================
module tb_vram_text_scanout;

   localparam int          BF  = 2;
   localparam logic [15:0] FGC = 16'hF81F;
   localparam logic [15:0] BGC = 16'h07E0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [8:0]  x = '0, y = '0;
   logic        de = 1'b0, frame_start = 1'b0, cursor_en = 1'b0;
   logic [9:0]  cursor_addr = '0;
   logic [9:0]  v_adb;
   logic        v_ceb, v_oce;
   logic [7:0]  v_dout = '0;
   logic [10:0] font_adr;
   logic [7:0]  font_dout = '0;
   logic [15:0] rgb;
   logic        rgb_de;

   vram_text_scanout #(
      .COLS(60), .ROWS(17), .FG(FGC), .BG(BGC), .BLINK_FRAMES(BF)
   ) dut (
      .MEMORY_CLK(clk), .reset(rst), .x(x), .y(y), .de(de),
      .frame_start(frame_start), .cursor_en(cursor_en), .cursor_addr(cursor_addr),
      .v_adb(v_adb), .v_ceb(v_ceb), .v_oce(v_oce), .v_dout(v_dout),
      .font_adr(font_adr), .font_dout(font_dout), .rgb(rgb), .rgb_de(rgb_de)
   );

   always #5 clk = ~clk;

   // Memory environment: two-register BSRAM read and one-register font ROM.
   logic [7:0] vram [0:1023];
   logic [7:0] font [0:2047];
   logic [7:0] vram_pipe = '0;
   always @(posedge clk) begin
      vram_pipe <= vram[v_adb];
      v_dout    <= vram_pipe;
      font_dout <= font[font_adr];
   end

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int m_cnt = 0;
   bit m_phase = 1'b1;
   logic        e_de  [16];
   logic [15:0] e_rgb [16];
   bit          f_chk [16];
   logic [10:0] f_adr [16];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) begin
         e_de[i]  = 1'b0;
         e_rgb[i] = BGC;
         f_chk[i] = 1'b0;
         f_adr[i] = '0;
      end
   endtask

   // One pixel clock: drive, predict from the text-mode rules, check outputs.
   task automatic step(input logic d, input int xx, input int yy, input logic fs);
      bit        inr, bitv, inv;
      int        addr, s5, s3, s0;
      logic [7:0] c, row;
      @(negedge clk);
      de = d; x = 9'(xx); y = 9'(yy); frame_start = fs;
      inr  = (xx < 480) && (yy < 272);
      addr = inr ? (yy / 16) * 60 + xx / 8 : 0;
      c    = vram[addr];
      row  = font[c[6:0] * 16 + yy % 16];
      bitv = row[7 - xx % 8];
      inv  = c[7] ^ (cursor_en && inr && (addr == int'(cursor_addr)) && m_phase);
      s5 = (cyc + 5) % 16;
      s3 = (cyc + 3) % 16;
      s0 = cyc % 16;
      e_de[s5]  = d && inr;
      e_rgb[s5] = (d && inr && (bitv ^ inv)) ? FGC : BGC;
      f_chk[s3] = inr;
      f_adr[s3] = 11'(c[6:0] * 16 + yy % 16);
      if (fs) begin
         if (m_cnt == BF - 1) begin
            m_cnt   = 0;
            m_phase = ~m_phase;
         end else begin
            m_cnt++;
         end
      end
      @(posedge clk);
      #1;
      check_val("v_adb", v_adb, 32'(addr));
      check_val("v_ceb", v_ceb, 1);
      check_val("v_oce", v_oce, 1);
      check_val("rgb_de", rgb_de, e_de[s0]);
      check_val("rgb", rgb, e_rgb[s0]);
      if (f_chk[s0]) check_val("font_adr", font_adr, f_adr[s0]);
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("rst_v_adb", v_adb, 0);
      check_val("rst_v_ceb", v_ceb, 0);
      check_val("rst_v_oce", v_oce, 0);
      check_val("rst_font_adr", font_adr, 0);
      check_val("rst_rgb", rgb, BGC);
      check_val("rst_rgb_de", rgb_de, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      clear_model();
      m_cnt   = 0;
      m_phase = 1'b1;
   endtask

   logic [7:0] glyph_a [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};

   initial begin
      int ly, px, py;
      for (int i = 0; i < 1024; i++) vram[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);
      for (int r = 0; r < 16; r++) font[16'h410 + r] = glyph_a[r];
      vram[0]  = 8'h41;
      vram[61] = 8'hC1;
      clear_model();
      do_reset();

      // Glyph 'A' cell, then its inverse copy, then address bounds.
      for (int yy = 0; yy < 16; yy++)
         for (int xx = 0; xx < 8; xx++) step(1'b1, xx, yy, 1'b0);
      step(1'b1, 8, 16, 1'b0);
      step(1'b1, 479, 271, 1'b0);
      step(1'b1, 480, 0, 1'b0);
      step(1'b1, 0, 272, 1'b0);
      repeat (6) step(1'b0, 0, 0, 1'b0);

      // Cursor on cell 5 across blink periods, then disabled.
      cursor_en = 1'b1; cursor_addr = 10'd5;
      for (int f = 0; f < 5; f++) begin
         for (int yy = 0; yy < 16; yy++) step(1'b1, 40 + (yy % 8), yy, 1'b0);
         step(1'b0, 0, 0, 1'b1);
      end
      cursor_en = 1'b0;
      for (int f = 0; f < 4; f++) begin
         for (int yy = 0; yy < 16; yy++) step(1'b1, 40 + (yy % 8), yy, 1'b0);
         step(1'b0, 0, 0, 1'b1);
      end

      // Full uninterrupted line.
      ly = $urandom_range(0, 271);
      for (int xx = 0; xx < 480; xx++) step(1'b1, xx, ly, 1'b0);

      // Random traffic with occasional frame pulses and cursor moves.
      cursor_en = 1'b1; cursor_addr = 10'($urandom_range(0, 1019));
      repeat (1500) begin
         if ($urandom % 64 == 0) begin
            cursor_en   = 1'($urandom % 2);
            cursor_addr = 10'($urandom_range(0, 1019));
         end
         if ($urandom % 4 == 0) begin
            py = (int'(cursor_addr) / 60) * 16 + $urandom_range(0, 15);
            px = (int'(cursor_addr) % 60) * 8 + $urandom_range(0, 7);
         end else begin
            px = $urandom_range(0, 511);
            py = $urandom_range(0, 300);
         end
         step(1'($urandom % 4 != 0), px, py, 1'($urandom % 40 == 0));
      end
      repeat (6) step(1'b0, 0, 0, 1'b0);

      // Reset in the middle of an active line with the cursor on that line.
      cursor_en = 1'b1; cursor_addr = 10'd91;
      repeat (5) step(1'b0, 0, 0, 1'b1);
      for (int xx = 0; xx < 480; xx++) begin
         if (xx == 200) do_reset();
         step(1'b1, xx, 20, 1'b0);
      end
      repeat (6) step(1'b0, 0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
